// File: rtl/m68k_sram_target.sv
// ---------------------------------------------------------------------------
// m68k_sram_target
//
// 68000-bus responder for on-board fast RAM. It watches AS/UDS/LDS/RW from
// any bus master and answers cycles that land inside an address window. The
// autoconfig logic supplies the window base and its enable. A hit runs a
// synchronous SRAM access with programmable wait states. The responder then
// asserts DTACK and, on reads, drives the data bus.
//
// Parameters:
//   SIZE_LOG2    window size as a power of two in bytes (16..23)
//   WAIT_STATES  extra clocks the SRAM strobes are held (0..7)
//
// Optional feature macro: SRAM_TARGET_MAPROM_WP_EN
//   When defined, the upper half of the window is write-protected for use as
//   a ROM shadow. Writes there are still acknowledged, but ram_we stays low.
//   When undefined, the whole window is writable.
//
// Ports:
//   M68K_CLK       bus clock; all state changes on its rising edge
//   RESET          synchronous, active-high reset
//   cfg_valid      window enable from autoconfig
//   cfg_base       window base, address bits [23:16]
//   M68K_A         bus address bits [23:1] (bit 0 of the port is A1)
//   M68K_AS_n      raw address strobe
//   M68K_UDS_n     raw upper data strobe
//   M68K_LDS_n     raw lower data strobe
//   M68K_RW        raw read/write line
//   M68K_D_IN      bus data as seen on the pins
//   M68K_D_OUT     read data to drive onto the bus
//   M68K_D_OE      read-data driver enable
//   M68K_DTACK_OE  top level pulls DTACK_n low while this is 1
//   ram_addr       SRAM word address
//   ram_be         SRAM byte enables, [1] upper byte, [0] lower byte
//   ram_ce         SRAM chip enable (active high)
//   ram_oe         SRAM output enable (active high)
//   ram_we         SRAM write enable (active high)
//   ram_wdata      SRAM write data
//   ram_rdata      SRAM read data
//   busy           high whenever the responder is not idle
// ---------------------------------------------------------------------------
module m68k_sram_target #(
  parameter int SIZE_LOG2   = 21,
  parameter int WAIT_STATES = 1
) (
  input  logic                 M68K_CLK,
  input  logic                 RESET,
  input  logic                 cfg_valid,
  input  logic [7:0]           cfg_base,
  input  logic [22:0]          M68K_A,
  input  logic                 M68K_AS_n,
  input  logic                 M68K_UDS_n,
  input  logic                 M68K_LDS_n,
  input  logic                 M68K_RW,
  input  logic [15:0]          M68K_D_IN,
  output logic [15:0]          M68K_D_OUT,
  output logic                 M68K_D_OE,
  output logic                 M68K_DTACK_OE,
  output logic [SIZE_LOG2-2:0] ram_addr,
  output logic [1:0]           ram_be,
  output logic                 ram_ce,
  output logic                 ram_oe,
  output logic                 ram_we,
  output logic [15:0]          ram_wdata,
  input  logic [15:0]          ram_rdata,
  output logic                 busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RSTROBE = 3'd1;
  localparam logic [2:0] WWAIT   = 3'd2;
  localparam logic [2:0] WSTROBE = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  // Synchroniser stages for the asynchronous bus strobes
  logic as_m, as_s;
  logic uds_m, uds_s;
  logic lds_m, lds_s;
  logic rw_m, rw_s;

  // Control state
  logic [2:0] state;
  logic [2:0] wait_cnt;
  logic       ack_r;
  logic       rw_r;
  logic       abort_r;
  logic       armed;

  // Latched cycle attributes
  logic [SIZE_LOG2-2:0] addr_r;
  logic [1:0]           be_r;
  logic [15:0]          wdata_r;
  logic [15:0]          rdata_r;

  logic hit;
  logic ds_any;
  logic strobe_last;
  logic wr_protect;
  logic cfg_unused;

  // Only the window-selecting bits of cfg_base take part in decode; the
  // reduction below just marks the rest as intentionally ignored.
  assign cfg_unused = ^cfg_base;

  // Two-flop synchronisers. They carry no reset on purpose. A reset that
  // forced them to the idle level would look like a fresh AS negation. That
  // would re-arm the decoder while a master still holds AS low.
  always_ff @(posedge M68K_CLK) begin
    as_m  <= M68K_AS_n;
    as_s  <= as_m;
    uds_m <= M68K_UDS_n;
    uds_s <= uds_m;
    lds_m <= M68K_LDS_n;
    lds_s <= lds_m;
    rw_m  <= M68K_RW;
    rw_s  <= rw_m;
  end

  // Window decode. The address bits above the window size must match the
  // corresponding base bits.
  assign hit = cfg_valid &&
               (M68K_A[22:SIZE_LOG2-1] == cfg_base[7:SIZE_LOG2-16]);

  assign ds_any      = !uds_s || !lds_s;
  assign strobe_last = (wait_cnt == 3'd0);

`ifdef SRAM_TARGET_MAPROM_WP_EN
  // The top address bit inside the window selects the protected half.
  assign wr_protect = addr_r[SIZE_LOG2-2];
`else
  assign wr_protect = 1'b0;
`endif

  // Main sequencer.
  // A bus cycle is accepted only after AS has been seen negated since the
  // previous one ("armed"). A master that keeps AS low across a reset is
  // therefore not served twice. An AS negation during the strobe phase is
  // remembered in abort_r. The SRAM access still runs to completion, so no
  // write is ever cut short, but DTACK is then withheld.
  always_ff @(posedge M68K_CLK) begin
    if (RESET) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      ack_r    <= 1'b0;
      rw_r     <= 1'b0;
      abort_r  <= 1'b0;
      armed    <= 1'b0;
      addr_r   <= '0;
      be_r     <= 2'b00;
      wdata_r  <= 16'h0000;
      rdata_r  <= 16'h0000;
    end else begin
      if (as_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (armed && !as_s && hit) begin
            if (rw_s) begin
              if (ds_any) begin
                state    <= RSTROBE;
                wait_cnt <= WAIT_LOAD;
                abort_r  <= 1'b0;
                armed    <= 1'b0;
                addr_r   <= M68K_A[SIZE_LOG2-2:0];
                be_r     <= {!uds_s, !lds_s};
                rw_r     <= 1'b1;
              end
            end else begin
              state  <= WWAIT;
              armed  <= 1'b0;
              addr_r <= M68K_A[SIZE_LOG2-2:0];
              be_r   <= {!uds_s, !lds_s};
              rw_r   <= 1'b0;
            end
          end
        end

        // The 68000 asserts its data strobes later than AS on writes. The
        // byte enables are therefore taken again once the data is valid.
        WWAIT: begin
          if (as_s) begin
            state <= IDLE;
          end else if (ds_any) begin
            state    <= WSTROBE;
            wait_cnt <= WAIT_LOAD;
            abort_r  <= 1'b0;
            be_r     <= {!uds_s, !lds_s};
            wdata_r  <= M68K_D_IN;
          end
        end

        RSTROBE, WSTROBE: begin
          if (as_s) begin
            abort_r <= 1'b1;
          end
          if (strobe_last) begin
            if (rw_r) begin
              rdata_r <= ram_rdata;
            end
            if (abort_r || as_s) begin
              state <= DONE;
            end else begin
              state <= ACK;
              ack_r <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        ACK: begin
          if (as_s) begin
            ack_r <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          ack_r <= 1'b0;
          state <= IDLE;
        end

        default: begin
          ack_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM strobes are decoded straight from the state. They therefore drop
  // on the same edge that enters ACK or DONE.
  always_comb begin
    ram_ce = (state == RSTROBE) || (state == WSTROBE);
    ram_oe = (state == RSTROBE);
    ram_we = (state == WSTROBE) && !wr_protect;
  end

  // DTACK and the data drivers are gated with the raw AS pin. They release
  // combinationally as soon as the master negates AS and do not wait for
  // the synchroniser.
  always_comb begin
    M68K_DTACK_OE = ack_r && !M68K_AS_n;
    M68K_D_OE     = ack_r && rw_r && !M68K_AS_n;
  end

  assign M68K_D_OUT = rdata_r;
  assign ram_addr   = addr_r;
  assign ram_be     = be_r;
  assign ram_wdata  = wdata_r;
  assign busy       = (state != IDLE);

endmodule
